hazard_unit_mc: RTL

- Next-generation hazard unit for the 5-stage RISC-V pipeline.
- Keeps EX-stage forwarding, load-use interlock and branch flush.
- Adds three things:
  - stalls for a multi-cycle mul/div unit in EX, via an FSM and counter;
  - whole-pipe freeze on a data-memory ready/valid handshake;
  - a saturating stall-cycle performance counter.
- Sits beside the pipeline registers; drives their stall/flush enables and the EX operand muxes.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_unit_mc_muldiv.sv | 54 +++++
 rtl/hazard_unit_mc.sv | 93 +++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and helpers for the hazard unit
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    IDLE,
    MD_BUSY
  } md_state_t;

  // Saturating increment; callers pass their all-ones value as the ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_unit_mc_muldiv.sv
// rtl/hazard_unit_mc_muldiv.sv - multi-cycle mul/div occupancy FSM for the EX stage
module muldiv_stall_ctr
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ID_EX_MulDiv,
  input  logic mem_wait,
  output logic md_stall,
  output logic md_busy
);

  localparam bit         MD_EN    = (MULDIV_LAT > 1);
  localparam logic [3:0] CNT_INIT = MD_EN ? 4'(MULDIV_LAT - 2) : 4'd0;

  md_state_t  state;
  logic [3:0] cnt;

  // The issuing cycle already stalls, so cnt only covers the remaining stall cycles.
  always_comb begin
    md_stall = 1'b0;
    case (state)
      IDLE:    md_stall = MD_EN && ID_EX_MulDiv && !mem_wait;
      MD_BUSY: md_stall = (cnt != 4'd0);
      default: md_stall = 1'b0;
    endcase
  end

  assign md_busy = md_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else if (!mem_wait) begin
      case (state)
        IDLE: begin
          if (MD_EN && ID_EX_MulDiv) begin
            state <= MD_BUSY;
            cnt   <= CNT_INIT;
          end
        end
        MD_BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - forwarding, interlock, mul/div and memory-wait stall control
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = 4,
  parameter int PERF_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] ID_EX_rs1,
  input  logic [REG_ADDR_W-1:0] ID_EX_rs2,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_EX_MulDiv,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
  input  logic [REG_ADDR_W-1:0] MEM_WB_rd,
  input  logic                  EX_MEM_RegWrite,
  input  logic                  MEM_WB_RegWrite,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  input  logic                  PCSrc,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  redirect_en,
  output logic                  md_busy,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic mem_wait;
  logic lw_stall;
  logic md_stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
    if (EX_MEM_RegWrite && (EX_MEM_rd != '0) && (EX_MEM_rd == src))
      return FWD_MEM;
    else if (MEM_WB_RegWrite && (MEM_WB_rd != '0) && (MEM_WB_rd == src))
      return FWD_WB;
    else
      return FWD_NONE;
  endfunction

  assign ForwardAE = fwd_sel(ID_EX_rs1);
  assign ForwardBE = fwd_sel(ID_EX_rs2);

  assign mem_wait = dmem_req && !dmem_ready;
  assign lw_stall = ID_EX_MemRead && (ID_EX_rd != '0) &&
                    ((rs1_used && (rs1 == ID_EX_rd)) ||
                     (rs2_used && (rs2 == ID_EX_rd)));

  muldiv_stall_ctr #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldiv (
    .clk          (clk),
    .rst_n        (rst_n),
    .ID_EX_MulDiv (ID_EX_MulDiv),
    .mem_wait     (mem_wait),
    .md_stall     (md_stall),
    .md_busy      (md_busy)
  );

  assign StallF = mem_wait || md_stall || lw_stall;
  assign StallD = StallF;
  assign StallE = mem_wait || md_stall;
  assign StallM = mem_wait;
  assign FlushW = mem_wait;

  // A taken branch only acts once EX actually advances; it wins over load-use.
  assign redirect_en = PCSrc && !StallE;
  assign FlushD      = redirect_en;
  assign FlushE      = redirect_en || (lw_stall && !StallE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (StallF)
      stall_cycles <= PERF_W'(sat_inc(32'(stall_cycles), 32'(PERF_MAX)));
  end

endmodule
